// File: rtl/dcache_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dcache_port_arbiter
//  Purpose  : Shares the single DCache request port between two requesters
//             (0 = LoadStoreQueue, 1 = auxiliary/debug master). Round-robin
//             arbitration into one registered issue stage. Reads are retagged
//             with an internal tag so both masters may reuse ldstIDs; returning
//             read data is routed back to the owner with its original ID.
//  Ports    : clk, rst (async, active-low)
//             rq_valid/rq_rw/rq_id/rq_addr/rq_wdata  -> requests, per requester
//             rq_stall                               <- combinational back-pressure
//             rs_valid/rs_id/rs_data                 <- read responses
//             mem_rd/mem_wr/mem_id/mem_addr/mem_wdata <- registered cache request
//             mem_stall                              -> cache back-pressure
//             mem_ready/mem_rid/mem_rdata            -> cache read return
//             tag_err                                <- sticky unknown-tag flag
//  Revision : 1.0 - initial release
// ============================================================================
module dcache_port_arbiter #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            rq_valid,
    input  logic [1:0]            rq_rw,
    input  logic [2*ID_W-1:0]     rq_id,
    input  logic [2*ADDR_W-1:0]   rq_addr,
    input  logic [2*DATA_W-1:0]   rq_wdata,
    output logic [1:0]            rq_stall,
    output logic [1:0]            rs_valid,
    output logic [ID_W-1:0]       rs_id,
    output logic [DATA_W-1:0]     rs_data,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [ID_W-1:0]       mem_id,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_stall,
    input  logic                  mem_ready,
    input  logic [ID_W-1:0]       mem_rid,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  tag_err
);

    localparam int c_NTAGS = 1 << ID_W;

    // Tag pool state: busy bit plus owner/original-ID per tag.
    logic [c_NTAGS-1:0]   r_busy;
    logic                 r_owner [c_NTAGS];
    logic [ID_W-1:0]      r_tid   [c_NTAGS];

    // Requester favoured when both are eligible; starts at requester 0 and
    // moves to the other requester after every actual grant.
    logic                 r_rr;

    // Issue register
    logic                 r_mem_rd;
    logic                 r_mem_wr;
    logic [ID_W-1:0]      r_mem_id;
    logic [ADDR_W-1:0]    r_mem_addr;
    logic [DATA_W-1:0]    r_mem_wdata;

    // Response register
    logic [1:0]           r_rs_valid;
    logic [ID_W-1:0]      r_rs_id;
    logic [DATA_W-1:0]    r_rs_data;
    logic                 r_tag_err;

    logic [ID_W-1:0]      w_free_tag;
    logic                 w_free_any;
    logic [1:0]           w_elig;
    logic [1:0]           w_grant;
    logic                 w_win;
    logic                 w_any_grant;
    logic                 w_sel_rw;
    logic [ID_W-1:0]      w_sel_id;
    logic [ADDR_W-1:0]    w_sel_addr;
    logic [DATA_W-1:0]    w_sel_wdata;
    logic                 w_alloc;
    logic                 w_rsp_hit;
    logic                 w_rsp_miss;
    logic [c_NTAGS-1:0]   w_busy_nxt;

    // Lowest-index free tag: scan downward so the last hit is the lowest.
    always_comb begin
        w_free_tag = '0;
        w_free_any = 1'b0;
        for (int i = c_NTAGS - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_free_tag = ID_W'(i);
                w_free_any = 1'b1;
            end
        end
    end

    // Writes are posted and need no tag; reads need one. Eligibility depends
    // only on registered tag state, so mem_ready never reaches rq_stall.
    assign w_elig = rq_valid & (rq_rw | {2{w_free_any}}) & {2{~mem_stall}};

    always_comb begin
        w_grant = 2'b00;
        w_win   = 1'b0;
        case (w_elig)
            2'b01: begin
                w_grant = 2'b01;
                w_win   = 1'b0;
            end
            2'b10: begin
                w_grant = 2'b10;
                w_win   = 1'b1;
            end
            2'b11: begin
                w_win   = r_rr;
                w_grant = r_rr ? 2'b10 : 2'b01;
            end
            default: begin
                w_grant = 2'b00;
                w_win   = 1'b0;
            end
        endcase
    end

    assign w_any_grant = |w_grant;
    assign rq_stall    = rq_valid & ~w_grant;

    assign w_sel_rw    = w_win ? rq_rw[1]                    : rq_rw[0];
    assign w_sel_id    = w_win ? rq_id[2*ID_W-1:ID_W]        : rq_id[ID_W-1:0];
    assign w_sel_addr  = w_win ? rq_addr[2*ADDR_W-1:ADDR_W]  : rq_addr[ADDR_W-1:0];
    assign w_sel_wdata = w_win ? rq_wdata[2*DATA_W-1:DATA_W] : rq_wdata[DATA_W-1:0];

    assign w_alloc    = w_any_grant & ~w_sel_rw;
    assign w_rsp_hit  = mem_ready &  r_busy[mem_rid];
    assign w_rsp_miss = mem_ready & ~r_busy[mem_rid];

    // A returning tag is busy and the allocated tag is free, so they are
    // always different and both updates apply in the same cycle.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_rsp_hit) begin
            w_busy_nxt[mem_rid] = 1'b0;
        end
        if (w_alloc) begin
            w_busy_nxt[w_free_tag] = 1'b1;
        end
    end

    // Issue stage: frozen (strobes included) while the cache stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_id    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rr        <= 1'b0;
        end else if (!mem_stall) begin
            r_mem_rd <= w_any_grant & ~w_sel_rw;
            r_mem_wr <= w_any_grant &  w_sel_rw;
            if (w_any_grant) begin
                r_mem_id    <= w_sel_rw ? '0 : w_free_tag;
                r_mem_addr  <= w_sel_addr;
                r_mem_wdata <= w_sel_wdata;
                r_rr        <= ~w_win;
            end
        end
    end

    // Tag pool
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy <= '0;
            for (int i = 0; i < c_NTAGS; i++) begin
                r_owner[i] <= 1'b0;
                r_tid[i]   <= '0;
            end
        end else begin
            r_busy <= w_busy_nxt;
            if (w_alloc) begin
                r_owner[w_free_tag] <= w_win;
                r_tid[w_free_tag]   <= w_sel_id;
            end
        end
    end

    // Response routing
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rs_valid <= 2'b00;
            r_rs_id    <= '0;
            r_rs_data  <= '0;
            r_tag_err  <= 1'b0;
        end else begin
            r_rs_valid <= 2'b00;
            if (w_rsp_hit) begin
                r_rs_valid <= {r_owner[mem_rid], ~r_owner[mem_rid]};
                r_rs_id    <= r_tid[mem_rid];
                r_rs_data  <= mem_rdata;
            end
            if (w_rsp_miss) begin
                r_tag_err <= 1'b1;
            end
        end
    end

    assign mem_rd    = r_mem_rd;
    assign mem_wr    = r_mem_wr;
    assign mem_id    = r_mem_id;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign rs_valid  = r_rs_valid;
    assign rs_id     = r_rs_id;
    assign rs_data   = r_rs_data;
    assign tag_err   = r_tag_err;

endmodule
`default_nettype wire

// File: tb/tb_dcache_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dcache_port_arbiter
//  Purpose  : Self-checking bench for dcache_port_arbiter. A transaction-level
//             reference (outstanding-tag table, tie-break pointer, expected
//             next-cycle outputs) is compared against the DUT every cycle;
//             directed scenarios add literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_port_arbiter;

    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int NT     = 16;

    logic                clk;
    logic                rst;
    logic [1:0]          rq_valid;
    logic [1:0]          rq_rw;
    logic [2*ID_W-1:0]   rq_id;
    logic [2*ADDR_W-1:0] rq_addr;
    logic [2*DATA_W-1:0] rq_wdata;
    logic [1:0]          rq_stall;
    logic [1:0]          rs_valid;
    logic [ID_W-1:0]     rs_id;
    logic [DATA_W-1:0]   rs_data;
    logic                mem_rd;
    logic                mem_wr;
    logic [ID_W-1:0]     mem_id;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                mem_stall;
    logic                mem_ready;
    logic [ID_W-1:0]     mem_rid;
    logic [DATA_W-1:0]   mem_rdata;
    logic                tag_err;

    dcache_port_arbiter #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .rq_valid(rq_valid), .rq_rw(rq_rw), .rq_id(rq_id),
        .rq_addr(rq_addr), .rq_wdata(rq_wdata), .rq_stall(rq_stall),
        .rs_valid(rs_valid), .rs_id(rs_id), .rs_data(rs_data),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_id(mem_id),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_stall(mem_stall), .mem_ready(mem_ready),
        .mem_rid(mem_rid), .mem_rdata(mem_rdata), .tag_err(tag_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Staged stimulus, applied at the next falling edge
    logic [1:0]        s_v, s_rw;
    logic [ID_W-1:0]   s_id0, s_id1, s_rid;
    logic [31:0]       s_a0, s_a1, s_d0, s_d1, s_rdata;
    logic              s_ms, s_mr;

    // Reference model state
    bit                busy_m [NT];
    bit                own_m  [NT];
    logic [ID_W-1:0]   id_m   [NT];
    bit                pri_m;            // requester that wins a tie
    bit                e_rd, e_wr, e_err;
    logic [ID_W-1:0]   e_mid, e_rsid;
    logic [31:0]       e_addr, e_wdata, e_rsdata;
    logic [1:0]        e_rsv;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        s_v = 2'b00; s_rw = 2'b00; s_id0 = '0; s_id1 = '0;
        s_a0 = '0; s_a1 = '0; s_d0 = '0; s_d1 = '0;
        s_ms = 1'b0; s_mr = 1'b0; s_rid = '0; s_rdata = '0;
    endtask

    function automatic int lowest_free();
        for (int i = 0; i < NT; i++) if (!busy_m[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NT; i++) begin
            busy_m[i] = 0; own_m[i] = 0; id_m[i] = '0;
        end
        pri_m = 0;
        e_rd = 0; e_wr = 0; e_err = 0; e_mid = '0; e_addr = '0; e_wdata = '0;
        e_rsv = 2'b00; e_rsid = '0; e_rsdata = '0;
    endtask

    // One clock of stimulus: apply inputs, compare everything the DUT shows
    // in this cycle, then advance the reference to the next cycle.
    task automatic cycle();
        int        ft;
        bit [1:0]  want;
        int        win;
        bit        hit;
        logic [1:0] e_stall;
        @(negedge clk);
        rq_valid = s_v; rq_rw = s_rw;
        rq_id    = {s_id1, s_id0};
        rq_addr  = {s_a1, s_a0};
        rq_wdata = {s_d1, s_d0};
        mem_stall = s_ms; mem_ready = s_mr; mem_rid = s_rid; mem_rdata = s_rdata;
        #1;
        // Arbitration decision for this cycle
        ft = lowest_free();
        for (int n = 0; n < 2; n++)
            want[n] = s_v[n] && (s_rw[n] || ft >= 0) && !s_ms;
        if (want == 2'b11)      win = pri_m;
        else if (want[0])       win = 0;
        else if (want[1])       win = 1;
        else                    win = -1;
        e_stall = s_v;
        if (win >= 0) e_stall[win] = 1'b0;

        chk("rq_stall", {62'd0, rq_stall}, {62'd0, e_stall});
        chk("mem_rd",   {63'd0, mem_rd},   {63'd0, e_rd});
        chk("mem_wr",   {63'd0, mem_wr},   {63'd0, e_wr});
        if (e_rd || e_wr) chk("mem_addr", {32'd0, mem_addr}, {32'd0, e_addr});
        if (e_rd || e_wr) chk("mem_id", {60'd0, mem_id}, {60'd0, e_mid});
        if (e_wr) chk("mem_wdata", {32'd0, mem_wdata}, {32'd0, e_wdata});
        chk("rs_valid", {62'd0, rs_valid}, {62'd0, e_rsv});
        if (e_rsv != 2'b00) begin
            chk("rs_id",   {60'd0, rs_id},   {60'd0, e_rsid});
            chk("rs_data", {32'd0, rs_data}, {32'd0, e_rsdata});
        end
        chk("tag_err", {63'd0, tag_err}, {63'd0, e_err});

        // Response side, judged against the tags outstanding this cycle
        hit   = s_mr && busy_m[s_rid];
        e_rsv = 2'b00;
        if (hit) begin
            e_rsv[own_m[s_rid]] = 1'b1;
            e_rsid   = id_m[s_rid];
            e_rsdata = s_rdata;
            busy_m[s_rid] = 0;
        end else if (s_mr) begin
            e_err = 1;
        end
        // Issue side
        if (!s_ms) begin
            e_rd = (win >= 0) && !s_rw[win];
            e_wr = (win >= 0) &&  s_rw[win];
            if (win >= 0) begin
                e_addr  = (win == 1) ? s_a1 : s_a0;
                e_wdata = (win == 1) ? s_d1 : s_d0;
                pri_m   = (win == 0);
                if (s_rw[win]) begin
                    e_mid = '0;
                end else begin
                    e_mid      = ID_W'(ft);
                    busy_m[ft] = 1;
                    own_m[ft]  = (win == 1);
                    id_m[ft]   = (win == 1) ? s_id1 : s_id0;
                end
            end
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        @(negedge clk);
        rst = 1'b0;
        rq_valid = 2'b00; rq_rw = 2'b00; rq_id = '0; rq_addr = '0; rq_wdata = '0;
        mem_stall = 1'b0; mem_ready = 1'b0; mem_rid = '0; mem_rdata = '0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        chk("reset mem_rd",   {63'd0, mem_rd},   64'd0);
        chk("reset mem_wr",   {63'd0, mem_wr},   64'd0);
        chk("reset rs_valid", {62'd0, rs_valid}, 64'd0);
        chk("reset tag_err",  {63'd0, tag_err},  64'd0);
        chk("reset rq_stall", {62'd0, rq_stall}, 64'd0);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        rq_valid = 2'b00; rq_rw = 2'b00; rq_id = '0; rq_addr = '0; rq_wdata = '0;
        mem_stall = 1'b0; mem_ready = 1'b0; mem_rid = '0; mem_rdata = '0;

        // Reset, then a single read and its response
        do_reset();
        idle(); s_v = 2'b01; s_id0 = 4'd5; s_a0 = 32'd40;
        cycle();
        settle();
        chk("single mem_rd",   {63'd0, mem_rd},   64'd1);
        chk("single mem_id",   {60'd0, mem_id},   64'd0);
        chk("single mem_addr", {32'd0, mem_addr}, 64'd40);
        idle(); cycle();
        idle(); s_mr = 1'b1; s_rid = 4'd0; s_rdata = 32'd9000;
        cycle();
        settle();
        chk("single rs_valid", {62'd0, rs_valid}, 64'd1);
        chk("single rs_id",    {60'd0, rs_id},    64'd5);
        chk("single rs_data",  {32'd0, rs_data},  64'd9000);
        idle(); cycle();

        // Contention: both requesters write for 4 cycles, grants 0,1,0,1
        do_reset();
        for (int k = 0; k < 4; k++) begin
            idle(); s_v = 2'b11; s_rw = 2'b11;
            s_a0 = 32'h100 + k; s_a1 = 32'h200 + k; s_d0 = k; s_d1 = 32'h10 + k;
            cycle();
            chk("contention stall", {62'd0, rq_stall}, (k % 2 == 0) ? 64'd2 : 64'd1);
        end
        idle(); cycle();

        // ID reuse across requesters, responses returned out of order
        do_reset();
        idle(); s_v = 2'b11; s_id0 = 4'd3; s_id1 = 4'd3; s_a0 = 32'h30; s_a1 = 32'h31;
        cycle();
        idle(); s_v = 2'b10; s_id1 = 4'd3; s_a1 = 32'h31;
        cycle();
        settle();
        chk("reuse tag1", {60'd0, mem_id}, 64'd1);
        idle(); cycle();
        idle(); s_mr = 1'b1; s_rid = 4'd1; s_rdata = 32'hAAAA;
        cycle();
        settle();
        chk("reuse rs_valid1", {62'd0, rs_valid}, 64'd2);
        chk("reuse rs_id1",    {60'd0, rs_id},    64'd3);
        idle(); s_mr = 1'b1; s_rid = 4'd0; s_rdata = 32'hBBBB;
        cycle();
        settle();
        chk("reuse rs_valid0", {62'd0, rs_valid}, 64'd1);
        chk("reuse rs_id0",    {60'd0, rs_id},    64'd3);
        idle(); cycle();

        // Pool full: 16 outstanding reads, write still flows, freed tag reused
        do_reset();
        for (int k = 0; k < NT; k++) begin
            idle(); s_v = 2'b01; s_id0 = ID_W'(k); s_a0 = 32'h1000 + k;
            cycle();
        end
        idle(); s_v = 2'b11; s_rw = 2'b10; s_id0 = 4'd2; s_a0 = 32'h2000;
        s_a1 = 32'h3000; s_d1 = 32'hCAFE;
        cycle();
        chk("full stall", {62'd0, rq_stall}, 64'd1);
        settle();
        chk("full write issues", {63'd0, mem_wr}, 64'd1);
        idle(); s_v = 2'b01; s_id0 = 4'd2; s_a0 = 32'h2000;
        s_mr = 1'b1; s_rid = 4'd7; s_rdata = 32'h77;
        cycle();
        chk("full still stalled", {62'd0, rq_stall}, 64'd1);
        idle(); s_v = 2'b01; s_id0 = 4'd2; s_a0 = 32'h2000;
        cycle();
        chk("freed tag grant", {62'd0, rq_stall}, 64'd0);
        settle();
        chk("freed tag id", {60'd0, mem_id}, 64'd7);
        idle(); cycle();

        // mem_stall freezes issue; response on an unallocated tag
        do_reset();
        idle(); s_v = 2'b01; s_id0 = 4'd1; s_a0 = 32'h55;
        cycle();
        for (int k = 0; k < 3; k++) begin
            idle(); s_v = 2'b11; s_ms = 1'b1; s_a0 = 32'h66; s_a1 = 32'h77;
            cycle();
            chk("stall no grant", {62'd0, rq_stall}, 64'd3);
            chk("stall held rd",  {63'd0, mem_rd},   64'd1);
            chk("stall held addr", {32'd0, mem_addr}, 64'h55);
        end
        idle(); s_mr = 1'b1; s_rid = 4'd9; s_rdata = 32'h99;
        cycle();
        settle();
        chk("bad tag err",      {63'd0, tag_err},  64'd1);
        chk("bad tag no resp",  {62'd0, rs_valid}, 64'd0);
        idle(); cycle();

        // Randomized traffic against the reference model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            int start;
            idle();
            s_v   = 2'($urandom_range(0, 3));
            s_rw  = 2'($urandom_range(0, 3));
            s_id0 = ID_W'($urandom); s_id1 = ID_W'($urandom);
            s_a0  = $urandom; s_a1 = $urandom; s_d0 = $urandom; s_d1 = $urandom;
            s_ms  = ($urandom_range(0, 4) == 0);
            s_rdata = $urandom;
            if ($urandom_range(0, 99) == 0) begin
                s_mr  = 1'b1;
                s_rid = ID_W'($urandom);
            end else if ($urandom_range(0, 2) != 0) begin
                start = $urandom_range(0, NT - 1);
                for (int j = 0; j < NT; j++) begin
                    if (!s_mr && busy_m[(start + j) % NT]) begin
                        s_mr  = 1'b1;
                        s_rid = ID_W'((start + j) % NT);
                    end
                end
            end
            cycle();
        end
        idle(); cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
